// File: rtl/bouncing_box_gen.sv
// Square sprite generator: moves a box around the visible frame at a button-adjustable
// tick period, reflects it off all four walls and paints it over a flat background.
module bouncing_box_gen #(
  parameter int          H_RES     = 640,
  parameter int          V_RES     = 480,
  parameter int          BOX_SIZE  = 40,
  parameter int          STEP      = 10,
  parameter int          DIV_W     = 26,
  parameter int unsigned DIV_INIT  = 33554432,
  parameter int unsigned DIV_DELTA = 4194304,
  parameter int unsigned DIV_MIN   = 4194304,
  parameter int unsigned DIV_MAX   = 67108863,
  parameter int          X_INIT    = 300,
  parameter int          Y_INIT    = 300,
  parameter logic [2:0]  BOX_RGB   = 3'b100,
  parameter logic [2:0]  BG_RGB    = 3'b110
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       push,
  input  logic             pause,
  input  logic [9:0]       pixel_x,
  input  logic [9:0]       pixel_y,
  input  logic             video_on,
  output logic [2:0]       rgb,
  output logic [9:0]       box_x,
  output logic [9:0]       box_y,
  output logic [1:0]       dir,
  output logic             bounce,
  output logic [DIV_W-1:0] period
);

  localparam logic [10:0]      XMAX    = 11'(H_RES - BOX_SIZE);
  localparam logic [10:0]      YMAX    = 11'(V_RES - BOX_SIZE);
  localparam logic [10:0]      STEP_W  = 11'(STEP);
  localparam logic [9:0]       STEP_P  = 10'(STEP);
  localparam logic [10:0]      SIZE_W  = 11'(BOX_SIZE);
  localparam logic [DIV_W:0]   DELTA_E = (DIV_W+1)'(DIV_DELTA);
  localparam logic [DIV_W:0]   MAX_E   = (DIV_W+1)'(DIV_MAX);
  localparam logic [DIV_W:0]   LOW_E   = (DIV_W+1)'(DIV_MIN + DIV_DELTA);
  localparam logic [DIV_W-1:0] DELTA_P = DIV_W'(DIV_DELTA);
  localparam logic [DIV_W-1:0] MIN_P   = DIV_W'(DIV_MIN);
  localparam logic [DIV_W-1:0] MAX_P   = DIV_W'(DIV_MAX);

  logic [9:0]       box_x_q, box_x_d, box_y_q, box_y_d;
  logic             dx_q, dx_d, dy_q, dy_d;
  logic [DIV_W-1:0] period_q, period_d, cnt_q, cnt_d;
  logic [1:0]       push_q;
  logic [2:0]       rgb_q, rgb_d;
  logic             bounce_q, bounce_d;

  logic [1:0]       edge_s;
  logic [DIV_W:0]   sum_s;
  logic             tick_s, box_on_s;
  logic [11:0]      mx_s, my_s;
  logic [10:0]      px_s, py_s, bx_s, by_s;

  // One axis step: returns {hit, new_dir, new_pos}; walls clamp before any unsigned wrap.
  function automatic logic [11:0] move_axis(input logic [9:0] pos, input logic d,
                                            input logic [10:0] lim);
    logic [10:0] p;
    p = {1'b0, pos};
    if (d) begin
      if (p + STEP_W >= lim) move_axis = {1'b1, 1'b0, lim[9:0]};
      else                   move_axis = {1'b0, 1'b1, pos + STEP_P};
    end else begin
      if (p <= STEP_W) move_axis = {1'b1, 1'b1, 10'd0};
      else             move_axis = {1'b0, 1'b0, pos - STEP_P};
    end
  endfunction

  assign edge_s = push & ~push_q;
  assign sum_s  = {1'b0, period_q} + DELTA_E;
  assign tick_s = !pause && (cnt_q >= period_q);
  assign mx_s   = move_axis(box_x_q, dx_q, XMAX);
  assign my_s   = move_axis(box_y_q, dy_q, YMAX);
  assign px_s   = {1'b0, pixel_x};
  assign py_s   = {1'b0, pixel_y};
  assign bx_s   = {1'b0, box_x_q};
  assign by_s   = {1'b0, box_y_q};
  assign box_on_s = (px_s >= bx_s) && (px_s < bx_s + SIZE_W) &&
                    (py_s >= by_s) && (py_s < by_s + SIZE_W);

  // Next-state: period saturation, tick counter, motion and pixel colour.
  always_comb begin
    period_d = period_q;
    case (edge_s)
      2'b01:   period_d = (sum_s > MAX_E) ? MAX_P : sum_s[DIV_W-1:0];
      2'b10:   period_d = ({1'b0, period_q} >= LOW_E) ? period_q - DELTA_P : MIN_P;
      default: period_d = period_q;
    endcase

    if (pause)       cnt_d = cnt_q;
    else if (tick_s) cnt_d = {DIV_W{1'b0}};
    else             cnt_d = cnt_q + DIV_W'(1'b1);

    if (tick_s) begin
      box_x_d  = mx_s[9:0];
      dx_d     = mx_s[10];
      box_y_d  = my_s[9:0];
      dy_d     = my_s[10];
      bounce_d = mx_s[11] | my_s[11];
    end else begin
      box_x_d  = box_x_q;
      dx_d     = dx_q;
      box_y_d  = box_y_q;
      dy_d     = dy_q;
      bounce_d = 1'b0;
    end

    if (!video_on)     rgb_d = 3'b000;
    else if (box_on_s) rgb_d = BOX_RGB;
    else               rgb_d = BG_RGB;
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      box_x_q  <= 10'(X_INIT);
      box_y_q  <= 10'(Y_INIT);
      dx_q     <= 1'b1;
      dy_q     <= 1'b1;
      period_q <= DIV_W'(DIV_INIT);
      cnt_q    <= {DIV_W{1'b0}};
      push_q   <= 2'b00;
      rgb_q    <= 3'b000;
      bounce_q <= 1'b0;
    end else begin
      box_x_q  <= box_x_d;
      box_y_q  <= box_y_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      push_q   <= push;
      rgb_q    <= rgb_d;
      bounce_q <= bounce_d;
    end
  end

  assign rgb    = rgb_q;
  assign box_x  = box_x_q;
  assign box_y  = box_y_q;
  assign dir    = {dx_q, dy_q};
  assign bounce = bounce_q;
  assign period = period_q;

endmodule

// File: tb/tb_bouncing_box_gen.sv
// Directed bench: three instances with different start positions share one stimulus stream.
module tb_bouncing_box_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  push = 2'b00;
  logic        pause = 1'b0;
  logic [9:0]  pixel_x = 10'd0, pixel_y = 10'd0;
  logic        video_on = 1'b0;

  logic [2:0]  rgb0, rgb1, rgb2;
  logic [9:0]  bx0, by0, bx1, by1, bx2, by2;
  logic [1:0]  dir0, dir1, dir2;
  logic        bn0, bn1, bn2;
  logic [25:0] per0, per1, per2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bouncing_box_gen #(.DIV_INIT(4), .DIV_DELTA(2), .DIV_MIN(2), .DIV_MAX(8)) dut0 (
    .clk(clk), .rst(rst), .push(push), .pause(pause), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .video_on(video_on), .rgb(rgb0), .box_x(bx0), .box_y(by0), .dir(dir0), .bounce(bn0),
    .period(per0));

  bouncing_box_gen #(.DIV_INIT(4), .DIV_DELTA(2), .DIV_MIN(2), .DIV_MAX(8), .X_INIT(595)) dut1 (
    .clk(clk), .rst(rst), .push(push), .pause(pause), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .video_on(video_on), .rgb(rgb1), .box_x(bx1), .box_y(by1), .dir(dir1), .bounce(bn1),
    .period(per1));

  bouncing_box_gen #(.DIV_INIT(4), .DIV_DELTA(2), .DIV_MIN(2), .DIV_MAX(8), .X_INIT(595),
                     .Y_INIT(435)) dut2 (
    .clk(clk), .rst(rst), .push(push), .pause(pause), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .video_on(video_on), .rgb(rgb2), .box_x(bx2), .box_y(by2), .dir(dir2), .bounce(bn2),
    .period(per2));

  typedef struct {
    logic [1:0]  push;
    logic [9:0]  px;
    logic [9:0]  py;
    logic        von;
    logic [25:0] per;
    logic [2:0]  rgb;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [1:0] p, input logic [9:0] x, input logic [9:0] y,
                     input logic v, input logic [25:0] pe, input logic [2:0] c);
    vec_t e;
    e.push = p; e.px = x; e.py = y; e.von = v; e.per = pe; e.rgb = c;
    tbl.push_back(e);
  endtask

  initial begin
    // Table under pause with dut0 parked at 320/320: period steps and pixel colours.
    add(2'b01, 10'd320, 10'd320, 1'b1, 26'd6, 3'b100);
    add(2'b00, 10'd360, 10'd320, 1'b1, 26'd6, 3'b110);
    add(2'b01, 10'd359, 10'd359, 1'b1, 26'd8, 3'b100);
    add(2'b00, 10'd319, 10'd320, 1'b1, 26'd8, 3'b110);
    add(2'b01, 10'd320, 10'd360, 1'b1, 26'd8, 3'b110);
    add(2'b00, 10'd320, 10'd320, 1'b0, 26'd8, 3'b000);
    add(2'b01, 10'd0,   10'd0,   1'b1, 26'd8, 3'b110);
    add(2'b00, 10'd0,   10'd0,   1'b0, 26'd8, 3'b000);
    add(2'b01, 10'd330, 10'd330, 1'b1, 26'd8, 3'b100);
    add(2'b00, 10'd0,   10'd0,   1'b0, 26'd8, 3'b000);
    add(2'b10, 10'd0,   10'd0,   1'b0, 26'd6, 3'b000);
    add(2'b00, 10'd0,   10'd0,   1'b0, 26'd6, 3'b000);
    add(2'b10, 10'd0,   10'd0,   1'b0, 26'd4, 3'b000);
    add(2'b00, 10'd0,   10'd0,   1'b0, 26'd4, 3'b000);
    add(2'b10, 10'd0,   10'd0,   1'b0, 26'd2, 3'b000);
    add(2'b00, 10'd0,   10'd0,   1'b0, 26'd2, 3'b000);
    add(2'b10, 10'd0,   10'd0,   1'b0, 26'd2, 3'b000);
    add(2'b00, 10'd0,   10'd0,   1'b0, 26'd2, 3'b000);
    add(2'b10, 10'd0,   10'd0,   1'b0, 26'd2, 3'b000);
    add(2'b00, 10'd0,   10'd0,   1'b0, 26'd2, 3'b000);
    add(2'b11, 10'd0,   10'd0,   1'b0, 26'd2, 3'b000);
    add(2'b00, 10'd0,   10'd0,   1'b0, 26'd2, 3'b000);
    add(2'b01, 10'd0,   10'd0,   1'b0, 26'd4, 3'b000);
    add(2'b00, 10'd0,   10'd0,   1'b0, 26'd4, 3'b000);
    add(2'b11, 10'd0,   10'd0,   1'b0, 26'd4, 3'b000);
    add(2'b00, 10'd0,   10'd0,   1'b0, 26'd4, 3'b000);
    add(2'b01, 10'd0,   10'd0,   1'b0, 26'd6, 3'b000);
    add(2'b01, 10'd0,   10'd0,   1'b0, 26'd6, 3'b000);
    add(2'b00, 10'd0,   10'd0,   1'b0, 26'd6, 3'b000);

    // Reset state.
    step();
    chk("rst_x", 32'(bx0), 32'd300);
    chk("rst_y", 32'(by0), 32'd300);
    chk("rst_dir", 32'(dir0), 32'd3);
    chk("rst_period", 32'(per0), 32'd4);
    chk("rst_rgb", 32'(rgb0), 32'd0);
    chk("rst_bounce", 32'(bn0), 32'd0);
    rst = 1'b0;

    // Free run: first tick on the fifth edge, wall hits on dut1/dut2.
    for (int k = 1; k <= 10; k++) begin
      step();
      chk("run_bounce0", 32'(bn0), 32'd0);
      if (k <= 4) begin
        chk("hold_x", 32'(bx0), 32'd300);
        chk("hold_y", 32'(by0), 32'd300);
      end else if (k <= 9) begin
        chk("tick1_x", 32'(bx0), 32'd310);
        chk("tick1_y", 32'(by0), 32'd310);
        chk("edge_x1", 32'(bx1), 32'd600);
        chk("edge_dir1", 32'(dir1), 32'd1);
        chk("corner_x2", 32'(bx2), 32'd600);
        chk("corner_y2", 32'(by2), 32'd440);
        chk("corner_dir2", 32'(dir2), 32'd0);
        chk("bounce1", 32'(bn1), (k == 5) ? 32'd1 : 32'd0);
        chk("bounce2", 32'(bn2), (k == 5) ? 32'd1 : 32'd0);
      end else begin
        chk("tick2_x", 32'(bx0), 32'd320);
        chk("tick2_y", 32'(by0), 32'd320);
        chk("back_x1", 32'(bx1), 32'd590);
        chk("back_x2", 32'(bx2), 32'd590);
        chk("back_y2", 32'(by2), 32'd430);
        chk("back_bounce2", 32'(bn2), 32'd0);
      end
    end

    // Paused table: buttons still act, motion frozen.
    pause = 1'b1;
    foreach (tbl[i]) begin
      push = tbl[i].push;
      pixel_x = tbl[i].px;
      pixel_y = tbl[i].py;
      video_on = tbl[i].von;
      step();
      chk($sformatf("tbl%0d_period", i), 32'(per0), 32'(tbl[i].per));
      chk($sformatf("tbl%0d_rgb", i), 32'(rgb0), 32'(tbl[i].rgb));
      chk($sformatf("tbl%0d_x", i), 32'(bx0), 32'd320);
    end

    // Unpause, raise period to 8, then shorten it while count sits at 7.
    pause = 1'b0;
    push = 2'b01;
    pixel_x = 10'd320;
    pixel_y = 10'd320;
    video_on = 1'b1;
    step();
    chk("slow_to8", 32'(per0), 32'd8);
    chk("unpause_x", 32'(bx0), 32'd320);
    push = 2'b00;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("count_hold_x", 32'(bx0), 32'd320);
    end
    push = 2'b10;
    step();
    chk("short_period", 32'(per0), 32'd6);
    chk("short_x_before", 32'(bx0), 32'd320);
    push = 2'b00;
    step();
    chk("short_tick_x", 32'(bx0), 32'd330);
    chk("short_tick_rgb", 32'(rgb0), 32'd4);

    // Asynchronous reset between edges.
    #3;
    rst = 1'b1;
    #1;
    chk("arst_x", 32'(bx0), 32'd300);
    chk("arst_y", 32'(by0), 32'd300);
    chk("arst_dir", 32'(dir0), 32'd3);
    chk("arst_period", 32'(per0), 32'd4);
    chk("arst_rgb", 32'(rgb0), 32'd0);
    chk("arst_x1", 32'(bx1), 32'd595);
    chk("arst_y2", 32'(by2), 32'd435);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_x", 32'(bx0), 32'd300);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bouncing_box_gen.md
Name: bouncing_box_gen

Overview:
Parametrised successor to the single-speed bouncing-square pixel generator. It moves one square sprite across the visible frame at a programmable tick period and reflects it off all four edges in a single tick. Button rising edges speed the sprite up or slow it down, with saturation at both limits. It sits between the VGA sync/timing block, which supplies pixel_x, pixel_y and video_on, and the RGB output pins.

Parameters:
H_RES, 640, visible width in pixels
V_RES, 480, visible height in pixels
BOX_SIZE, 40, square edge length in pixels
STEP, 10, pixels moved per axis per tick (must be less than H_RES-BOX_SIZE and V_RES-BOX_SIZE)
DIV_W, 26, width of the tick period counter
DIV_INIT, 33554432, period after reset, in clk cycles
DIV_DELTA, 4194304, period change per button press
DIV_MIN, 4194304, minimum period (fastest speed)
DIV_MAX, 67108863, maximum period (slowest speed; must be at most 2^DIV_W-1)
X_INIT, 300, reset x position
Y_INIT, 300, reset y position
BOX_RGB, 3'b100, colour inside the square
BG_RGB, 3'b110, background colour

Ports:
clk  input  1  system/pixel clock
rst  input  1  asynchronous active-high reset
push  input  2  buttons, already debounced and synchronous to clk; bit0 = slower, bit1 = faster
pause  input  1  level; when 1, motion and the period counter are frozen
pixel_x  input  10  current pixel column
pixel_y  input  10  current pixel row
video_on  input  1  high inside the visible area
rgb  output  3  registered pixel colour
box_x  output  10  current square left edge
box_y  output  10  current square top edge
dir  output  2  bit1 = dx (1 = +x), bit0 = dy (1 = +y)
bounce  output  1  one-cycle pulse on any wall reflection
period  output  DIV_W  current tick period

Behaviour:
- Reset (asynchronous, active-high, clk is the only clock):
  - box_x=X_INIT, box_y=Y_INIT, dir=2'b11, period=DIV_INIT.
  - Counter=0, push edge register=0, rgb=0, bounce=0.
- Button edges: register push each cycle; edge = push & ~push_q.
  - Slower edge only: period = min(period+DIV_DELTA, DIV_MAX).
  - Faster edge only: period = max(period-DIV_DELTA, DIV_MIN).
  - Both edges in the same cycle: no change.
  - Compute the sum at DIV_W+1 bits so it cannot wrap.
  - Updates apply while pause=1.
- Tick counter:
  - pause=1: counter holds.
  - Otherwise, when count >= period: count goes to 0 and a move tick fires. Using >= ensures a shortened period cannot be missed.
  - Otherwise count increments.
  - Tick period is therefore period+1 cycles.
- Move tick, each axis independent. Let XMAX=H_RES-BOX_SIZE and YMAX=V_RES-BOX_SIZE.
  - dx=1, box_x+STEP >= XMAX: box_x=XMAX, dx goes to 0, bounce.
  - dx=0, box_x <= STEP: box_x=0, dx goes to 1, bounce.
  - Otherwise box_x moves by ±STEP.
  - The y axis behaves identically with dy and YMAX.
  - A corner hit flips both bits in the same tick and produces a single bounce pulse.
  - Position never leaves [0,XMAX] x [0,YMAX]. No unsigned wrap is permitted.
- bounce is registered and high exactly for the cycle after the reflecting tick. Otherwise it is 0.
- Pixel output, one-cycle latency:
  - box_on = (pixel_x >= box_x) && (pixel_x < box_x+BOX_SIZE) && (pixel_y >= box_y) && (pixel_y < box_y+BOX_SIZE), using the registered position.
  - rgb is registered: video_on=0 gives 0; box_on gives BOX_RGB; otherwise BG_RGB.
  - The sync block delays hsync/vsync by one cycle to match.
- Reset mid-operation: all state returns to reset values immediately. Period does not carry over.

Test Plan:
- Use DIV_INIT=4, DIV_DELTA=2, DIV_MIN=2, DIV_MAX=8 unless noted.
- Reset then release, no buttons: box_x/box_y are 300/300 for 5 cycles, then 310/310. A tick fires every 5 cycles. bounce stays 0.
- X_INIT=595 (XMAX=600), dir=11: the first tick gives box_x=600 and dir=01 with one bounce pulse. The next tick gives box_x=590.
- X_INIT=595, Y_INIT=435 (YMAX=440): the tick gives 600/440, dir=00, and exactly one bounce pulse.
- Five slower edges give period 6, 8, 8, 8, 8. Then five faster edges give 6, 4, 2, 2, 2. Both buttons rising in the same cycle leave period unchanged.
- With period=8, count=7, a faster edge sets period=6. count>=period on the next compare, so the tick fires and count returns to 0.
- Position 300/300, pixel (300,300) with video_on=1: rgb=100 one cycle later. Pixel (340,300): rgb=110. video_on=0: rgb=000.
- Hold pause for 20 cycles: position and count hold, and a press during pause still changes period. Asserting rst asynchronously mid-tick: outputs show reset values before the next clk edge.
